// File: rtl/z2_bus_pkg.sv
// Shared definitions for the Z2-space 68000-style bus initiator.
// Contents: FSM state enum, request payload struct, lane encodings
// ({UDS, LDS} active-high), timeout counter width and default timeout.
package z2_bus_pkg;

  localparam int unsigned ADDR_W             = 24;
  localparam int unsigned DATA_W             = 16;
  localparam int unsigned CNT_W              = 8;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_ASSERT = 3'd2,
    ST_DSW    = 3'd3,
    ST_WAIT   = 3'd4,
    ST_LATCH  = 3'd5,
    ST_END    = 3'd6
  } bus_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              rw;        // 1 = read
    logic              byte_acc;  // 1 = byte access
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

  // Lane enables as {uds, lds}, active-high.
  localparam logic [1:0] LANE_WORD  = 2'b11;
  localparam logic [1:0] LANE_UPPER = 2'b10;  // even byte, D[15:8]
  localparam logic [1:0] LANE_LOWER = 2'b01;  // odd byte, D[7:0]

  // Select data strobes from access size and address bit 0.
  function automatic logic [1:0] lane_sel(input logic byte_acc, input logic a0);
    if (!byte_acc) begin
      return LANE_WORD;
    end
    return a0 ? LANE_LOWER : LANE_UPPER;
  endfunction

endpackage

// File: rtl/dtack_sync.sv
// Multi-stage synchronizer for the asynchronous, active-low DTACK_n input.
// All stages reset to 1 (negated).
// Ports: clk, rst_n (async active-low), async_n (raw DTACK_n),
//        sync_n (synchronized DTACK_n).
module dtack_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_n,
  output logic sync_n
);

  logic [STAGES-1:0] ff_q;

  // Shift chain; oldest sample at the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_q <= '1;
    end else begin
      ff_q <= {ff_q[STAGES-2:0], async_n};
    end
  end

  assign sync_n = ff_q[STAGES-1];

endmodule

// File: rtl/m68k_bus_initiator.sv
// 68000-style asynchronous bus cycle initiator for the Z2 memory bus.
// Accepts one request over REQ/ACK, runs an AS_n/UDS_n/LDS_n/RW_n cycle,
// terminates on synchronized DTACK_n (or a timeout that flags BERR) and
// reports completion with a DONE pulse carrying RDATA/BERR.
// Every output is registered: the action of each state appears on the
// outputs in the cycle after that state.
// Ports:
//   CLK, RESET_n                     clock, async active-low reset
//   REQ, REQ_ADDR, REQ_RW, REQ_BYTE, REQ_WDATA   request (hold until ACK)
//   ACK, DONE, RDATA, BERR           handshake / completion
//   A, D_OUT, D_OE, D_IN             bus address and data
//   AS_n, UDS_n, LDS_n, RW_n, DTACK_n bus control
//   RAM_ACCESS                       fastram decode hit
// Build option: INTERNAL_DTACK_EN -- RAM_ACCESS terminates WAIT like DTACK.
module m68k_bus_initiator
  import z2_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES    = TIMEOUT_CYCLES_DEF,
  parameter int unsigned DTACK_SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic        REQ,
  input  logic [23:0] REQ_ADDR,
  input  logic        REQ_RW,
  input  logic        REQ_BYTE,
  input  logic [15:0] REQ_WDATA,
  output logic        ACK,
  output logic        DONE,
  output logic [15:0] RDATA,
  output logic        BERR,
  output logic [22:0] A,
  output logic [15:0] D_OUT,
  output logic        D_OE,
  input  logic [15:0] D_IN,
  output logic        AS_n,
  output logic        UDS_n,
  output logic        LDS_n,
  output logic        RW_n,
  input  logic        DTACK_n,
  input  logic        RAM_ACCESS
);

  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);

  bus_state_e        state_q, state_d;
  bus_req_t          req_q, req_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              err_q, err_d;
  logic              ack_d, done_d, berr_d;
  logic              as_n_d, uds_n_d, lds_n_d, rw_n_d, d_oe_d;
  logic [15:0]       rdata_d, d_out_d;
  logic [22:0]       a_d;
  logic [1:0]        lane;
  logic              dtack_sync_n;
  logic              term;
  logic              timeout_hit;

  dtack_sync #(
    .STAGES (DTACK_SYNC_STAGES)
  ) u_dtack_sync (
    .clk     (CLK),
    .rst_n   (RESET_n),
    .async_n (DTACK_n),
    .sync_n  (dtack_sync_n)
  );

  // Cycle termination source.
`ifdef INTERNAL_DTACK_EN
  assign term = !dtack_sync_n || RAM_ACCESS;
`else
  logic unused_ram_access;
  assign unused_ram_access = RAM_ACCESS;
  assign term = !dtack_sync_n;
`endif

  assign lane        = lane_sel(req_q.byte_acc, req_q.addr[0]);
  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign timeout_hit = (cnt_inc == TIMEOUT_LIM);

  // State and registered outputs.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ACK     <= 1'b0;
      DONE    <= 1'b0;
      BERR    <= 1'b0;
      RDATA   <= '0;
      A       <= '0;
      D_OUT   <= '0;
      D_OE    <= 1'b0;
      AS_n    <= 1'b1;
      UDS_n   <= 1'b1;
      LDS_n   <= 1'b1;
      RW_n    <= 1'b1;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ACK     <= ack_d;
      DONE    <= done_d;
      BERR    <= berr_d;
      RDATA   <= rdata_d;
      A       <= a_d;
      D_OUT   <= d_out_d;
      D_OE    <= d_oe_d;
      AS_n    <= as_n_d;
      UDS_n   <= uds_n_d;
      LDS_n   <= lds_n_d;
      RW_n    <= rw_n_d;
    end
  end

  // Next-state logic; DTACK beats the timeout when both occur together.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (REQ) state_d = ST_ADDR;
      ST_ADDR:   state_d = ST_ASSERT;
      ST_ASSERT: state_d = req_q.rw ? ST_WAIT : ST_DSW;
      ST_DSW:    state_d = ST_WAIT;
      ST_WAIT: begin
        if (term) begin
          state_d = ST_LATCH;
        end else if (timeout_hit) begin
          state_d = ST_END;
        end
      end
      ST_LATCH:  state_d = ST_END;
      ST_END:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    req_d   = req_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ack_d   = 1'b0;
    done_d  = 1'b0;
    berr_d  = BERR;
    rdata_d = RDATA;
    a_d     = A;
    d_out_d = D_OUT;
    d_oe_d  = D_OE;
    as_n_d  = AS_n;
    uds_n_d = UDS_n;
    lds_n_d = LDS_n;
    rw_n_d  = RW_n;
    case (state_q)
      ST_IDLE: begin
        rw_n_d = 1'b1;
        d_oe_d = 1'b0;
        if (REQ) begin
          ack_d = 1'b1;
          req_d = '{addr: REQ_ADDR, rw: REQ_RW, byte_acc: REQ_BYTE, wdata: REQ_WDATA};
        end
      end
      ST_ADDR: begin
        a_d    = req_q.addr[23:1];
        rw_n_d = req_q.rw;
        cnt_d  = '0;
        err_d  = 1'b0;
        if (!req_q.rw) begin
          d_out_d = req_q.wdata;
        end
      end
      ST_ASSERT: begin
        as_n_d = 1'b0;
        if (req_q.rw) begin
          uds_n_d = !lane[1];
          lds_n_d = !lane[0];
        end else begin
          d_oe_d = 1'b1;
        end
      end
      ST_DSW: begin
        uds_n_d = !lane[1];
        lds_n_d = !lane[0];
      end
      ST_WAIT: begin
        if (!term) begin
          cnt_d = cnt_inc;
          if (timeout_hit) begin
            err_d = 1'b1;
          end
        end
      end
      ST_LATCH: begin
        if (req_q.rw) begin
          rdata_d = D_IN;
        end
      end
      ST_END: begin
        as_n_d  = 1'b1;
        uds_n_d = 1'b1;
        lds_n_d = 1'b1;
        done_d  = 1'b1;
        berr_d  = err_q;
        if (err_q) begin
          rdata_d = '0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/m68k_bus_initiator.md
Name: m68k_bus_initiator

Overview:
- Local-side master that runs 68000-style asynchronous bus cycles (AS_n/UDS_n/LDS_n/RW_n, DTACK_n termination) on the card's Z2-space memory bus.
- It is the initiating end of the cycles that the fastram address decoder and RAM banks answer.
- Used by the on-card DMA/test engine to read and write fastram and other Z2 targets.
- Accepts one request at a time over a valid/ack handshake, synchronizes DTACK_n, and returns read data or a bus-error flag on timeout.

Parameters:
- TIMEOUT_CYCLES, 64: number of WAIT cycles without DTACK before a bus-error termination (range 2..255).
- DTACK_SYNC_STAGES, 2: flip-flop stages on DTACK_n (range 2..3).

Ports:
- CLK  in  1  system clock.
- RESET_n  in  1  asynchronous active-low reset.
- REQ  in  1  request valid; hold REQ_* stable until ACK.
- REQ_ADDR  in  24  byte address; bit 0 selects the byte lane.
- REQ_RW  in  1  1=read, 0=write.
- REQ_BYTE  in  1  1=byte access, 0=word access (REQ_ADDR[0] must be 0).
- REQ_WDATA  in  16  write data; for byte accesses it is placed on both halves by the requester.
- ACK  out  1  one-cycle pulse: request accepted.
- DONE  out  1  one-cycle pulse: cycle finished.
- RDATA  out  16  read data, valid with DONE, held until next DONE.
- BERR  out  1  valid with DONE; 1 = timeout.
- A  out  23  bus address A[23:1].
- D_OUT  out  16  write data to bus.
- D_OE  out  1  data bus drive enable.
- D_IN  in  16  read data from bus.
- AS_n, UDS_n, LDS_n  out  1 each  strobes.
- RW_n  out  1  bus direction.
- DTACK_n  in  1  asynchronous termination.
- RAM_ACCESS  in  1  fastram decode hit; used only with the optional feature.

Behaviour:
- Reset values: AS_n=UDS_n=LDS_n=RW_n=1, D_OE=0, ACK=DONE=BERR=0, RDATA=0, A=0, D_OUT=0, synchronizer flops=1, state=IDLE.
- Reset is asynchronous and may assert mid-cycle; all strobes negate immediately and no DONE is produced.
- Lane enables:
  - word access: UDS and LDS both asserted.
  - byte access with ADDR[0]=0: UDS only (even byte, D[15:8]).
  - byte access with ADDR[0]=1: LDS only (odd byte, D[7:0]).
- State sequence, relative to the accept cycle T0:
  - IDLE: REQ=1 gives ACK=1 in this cycle (T0), latches the REQ_* fields, and moves to ADDR.
  - ADDR (T1): drive A and RW_n; for writes also drive D_OUT. Strobes stay negated.
  - ASSERT (T2): AS_n=0. Reads also assert the selected DS in this cycle. Writes set D_OE=1 and go next to DSW. Reads go next to WAIT.
  - DSW (T3, writes only): assert the selected DS, then go to WAIT.
  - WAIT: the timeout counter increments each cycle.
    - Synchronized DTACK_n==0: go to LATCH.
    - Counter reaches TIMEOUT_CYCLES: go to END with the error flag set.
  - LATCH: reads register D_IN into RDATA; writes take no data action. Go to END.
  - END: negate AS_n, UDS_n and LDS_n; DONE=1; BERR=error flag. On timeout, RDATA is set to 0. Go to IDLE.
  - IDLE entry: RW_n=1 and D_OE=0 (D_OE stays on through END, giving hold time after DS negation).
- Minimum latency with DTACK held low and already synchronized:
  - read: DONE at T5.
  - write: DONE at T6.
- The DTACK synchronizer runs continuously. DTACK is sampled only in WAIT.
- A new request is accepted no earlier than the cycle after END, giving one recovery IDLE cycle with strobes high.
- REQ held continuously produces back-to-back cycles with that gap.
- Timeout counter is 8 bits and cleared in ADDR.
- A DTACK arriving in the same cycle that the counter reaches TIMEOUT_CYCLES wins: normal termination, BERR=0.

Optional Feature:
- Macro: INTERNAL_DTACK_EN.
- Defined: in WAIT, RAM_ACCESS==1 terminates the cycle exactly like a synchronized DTACK (zero-wait fastram), bypassing the synchronizer.
- Not defined: RAM_ACCESS is ignored and only DTACK_n terminates.

Decomposition:
- Shared package (z2_bus_pkg): state enum, lane-encoding constants, default TIMEOUT_CYCLES.
- One sub-module, dtack_sync: DTACK_SYNC_STAGES-deep synchronizer that resets to 1.

Test Plan:
- Word read, DTACK tied low, D_IN=16'hBEEF, REQ_ADDR=24'h200000 → ACK at T0, AS_n low T2..T4, UDS_n=LDS_n=0, A=23'h100000, DONE at T5 with RDATA=16'hBEEF, BERR=0.
- Byte write, ADDR=24'h200001, WDATA=16'h00A5, DTACK low → LDS_n low from T3, UDS_n stays 1, RW_n=0 from T1, D_OE high T2..T6, DONE at T6.
- DTACK never asserted, read → DONE at T(2+TIMEOUT_CYCLES+1)=T67, BERR=1, RDATA=0, all strobes high afterwards.
- DTACK asserted 5 cycles after AS_n falls, REQ held high → correct single termination, then one IDLE cycle, then a second ACK; the strobes never glitch between cycles.
- RESET_n pulsed low during WAIT → AS_n/UDS_n/LDS_n/RW_n=1 and D_OE=0 without a clock edge; no DONE; next request completes normally.
- With INTERNAL_DTACK_EN defined, RAM_ACCESS=1 and DTACK_n=1 → read DONE at T5 with data latched. Without the macro, the same stimulus gives a timeout (BERR=1).
